// File: rtl/spi_master_param_pkg.sv
// spi_master_param_pkg: shared constants, state encoding and SPI mode values for the SPI master
package spi_master_param_pkg;

    localparam int MASTER_FRAME_WIDTH   = 32;
    localparam int CLKS_PER_MASTER_SCLK = 3;
    localparam int DEFAULT_FRAME_WIDTH  = MASTER_FRAME_WIDTH;
    localparam int DEFAULT_CLK_DIV      = CLKS_PER_MASTER_SCLK;

    localparam logic CS_ASSERT   = 1'b0;
    localparam logic CS_DEASSERT = 1'b1;

    // {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-period counter and SCLK edge sequencing strobes
module spi_sclk_gen #(
    parameter int FRAME_WIDTH = 32,
    parameter int CLK_DIV     = 3
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic run,
    input  logic xfer,
    output logic tick,
    output logic lead_edge,
    output logic trail_edge,
    output logic last_edge
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * FRAME_WIDTH);

    logic [CW-1:0] cnt;
    logic [EW-1:0] ecnt;

    assign tick       = cnt == CW'(CLK_DIV - 1);
    assign last_edge  = ecnt == EW'(2 * FRAME_WIDTH - 1);
    assign lead_edge  = xfer && tick && !ecnt[0];
    assign trail_edge = xfer && tick && ecnt[0];

    // half-period counter runs outside IDLE; edge counter counts toggles during XFER only
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            ecnt <= '0;
        end else begin
            cnt  <= (!run || tick) ? '0 : cnt + 1'b1;
            ecnt <= (!xfer || (tick && last_edge)) ? '0 : ecnt + EW'(tick);
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: run-time mode-selectable, full-duplex MSB-first SPI master with multiple chip selects
module spi_master_param
    import spi_master_param_pkg::*;
#(
    parameter int FRAME_WIDTH = DEFAULT_FRAME_WIDTH,
    parameter int CLK_DIV     = DEFAULT_CLK_DIV,
    parameter int NUM_CS      = 2,
    parameter int CS_SEL_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                   sysclk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic                   i_cpol,
    input  logic                   i_cpha,
    input  logic [CS_SEL_W-1:0]    i_cs_sel,
    input  logic [FRAME_WIDTH-1:0] i_frame,
    input  logic                   miso,
    output logic                   sclk,
    output logic                   mosi,
    output logic [NUM_CS-1:0]      cs_n,
    output logic                   o_busy,
    output logic [FRAME_WIDTH-1:0] o_rx_frame,
    output logic                   o_rx_dv
);
    state_t                 state;
    logic                   cpol_q;
    logic                   cpha_q;
    logic [FRAME_WIDTH-1:0] tx_sr;
    logic [FRAME_WIDTH-1:0] rx_sr;
    logic                   tick;
    logic                   lead_edge;
    logic                   trail_edge;
    logic                   last_edge;
    logic                   accept;

    // o_busy stays high for one IDLE cycle after GAP, so a new start lands the cycle after it falls
    assign accept = (state == IDLE) && !o_busy && i_start && (32'(i_cs_sel) < NUM_CS);

    spi_sclk_gen #(
        .FRAME_WIDTH(FRAME_WIDTH),
        .CLK_DIV    (CLK_DIV)
    ) u_sclk_gen (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .run       (state != IDLE),
        .xfer      (state == XFER),
        .tick      (tick),
        .lead_edge (lead_edge),
        .trail_edge(trail_edge),
        .last_edge (last_edge)
    );

    // transaction sequencer with shift registers and registered SPI outputs
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= {NUM_CS{CS_DEASSERT}};
            o_busy     <= 1'b0;
            o_rx_frame <= '0;
            o_rx_dv    <= 1'b0;
        end else begin
            o_rx_dv <= 1'b0;
            case (state)
                IDLE: begin
                    o_busy <= accept;
                    sclk   <= accept ? i_cpol : cpol_q;
                    if (accept) begin
                        cpol_q <= i_cpol;
                        cpha_q <= i_cpha;
                        tx_sr  <= i_frame;
                        cs_n   <= ~(NUM_CS'(1) << i_cs_sel);
                        mosi   <= i_cpha ? mosi : i_frame[FRAME_WIDTH-1];
                        state  <= LEAD;
                    end
                end
                LEAD: state <= tick ? XFER : LEAD;
                XFER: begin
                    if (lead_edge || trail_edge)
                        sclk <= ~sclk;
                    if (lead_edge && cpha_q) begin
                        mosi  <= tx_sr[FRAME_WIDTH-1];
                        tx_sr <= tx_sr << 1;
                    end
                    if ((lead_edge && !cpha_q) || (trail_edge && cpha_q))
                        rx_sr <= {rx_sr[FRAME_WIDTH-2:0], miso};
                    if (trail_edge && !cpha_q && !last_edge) begin
                        mosi  <= tx_sr[FRAME_WIDTH-2];
                        tx_sr <= tx_sr << 1;
                    end
                    if (trail_edge && last_edge)
                        state <= TRAIL;
                end
                TRAIL: begin
                    if (tick) begin
                        cs_n       <= {NUM_CS{CS_DEASSERT}};
                        o_rx_frame <= rx_sr;
                        o_rx_dv    <= 1'b1;
                        mosi       <= 1'b0;
                        state      <= GAP;
                    end
                end
                GAP:     state <= tick ? IDLE : GAP;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
